// File: rtl/mem_access_unit.sv
// Load/store engine: accepts one RV load/store request, drives a word-aligned
// memory port with byte enables, steers sub-word lanes, extends load data and
// reports misalignment, illegal funct3 and response timeouts.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [2:0]          i_req_funct3,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_resp_valid,
  output logic                o_resp_err,
  output logic [XLEN-1:0]     o_resp_rdata,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic [ADDR_W-1:0]   o_mem_address,
  output logic [XLEN-1:0]     o_mem_wdata,
  output logic [XLEN/8-1:0]   o_mem_byte_enable,
  input  logic [XLEN-1:0]     i_mem_rdata,
  input  logic                i_mem_resp
);

  localparam int BE_W   = XLEN / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 2);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "mem_access_unit: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_funct3;
  logic                r_write;
  logic [XLEN-1:0]     r_wdata;
  logic                r_err;
  logic [XLEN-1:0]     r_rdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_legal;
  logic                w_misaligned;
  logic [1:0]          w_size;
  logic [LANE_W-1:0]   w_lane;
  logic                w_timeout;
  logic [BE_W-1:0]     w_size_be;
  logic [XLEN-1:0]     w_size_mask;
  logic [XLEN-1:0]     w_rep;
  logic [XLEN-1:0]     w_shift;
  logic                w_sign;
  logic [XLEN-1:0]     w_ext;

  // Classify the incoming request: legal access size and natural alignment
  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
      3'b011, 3'b110:                         w_legal = (XLEN == 64);
      default:                                w_legal = 1'b0;
    endcase
    // unsigned variants only exist for loads
    if (i_req_write && i_req_funct3[2]) w_legal = 1'b0;
    for (int i = 0; i < LANE_W; i++) begin
      if (i < int'(i_req_funct3[1:0]) && i_req_addr[i]) w_misaligned = 1'b1;
    end
  end

  assign w_size    = r_funct3[1:0];
  assign w_lane    = r_addr[LANE_W-1:0];
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Size masks, replicated store data and extended load data for the captured request
  always_comb begin
    w_size_be   = '0;
    w_size_mask = '0;
    w_rep       = '0;
    for (int i = 0; i < BE_W; i++) begin
      w_size_be[i]    = (i < (1 << w_size));
      w_rep[i*8 +: 8] = r_wdata[(i & ((1 << w_size) - 1))*8 +: 8];
    end
    for (int i = 0; i < XLEN; i++) begin
      w_size_mask[i] = (i < (8 << w_size));
    end
    w_shift = i_mem_rdata >> {w_lane, 3'b000};
    w_sign  = w_shift[((8 << w_size) - 1) & (XLEN - 1)] & ~r_funct3[2];
    w_ext   = (w_shift & w_size_mask) | ({XLEN{w_sign}} & ~w_size_mask);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: bad requests skip the memory, mem_resp beats the timeout
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_req_valid) w_state_next = (w_legal && !w_misaligned) ? S_ACCESS : S_DONE;
      S_ACCESS: if (i_mem_resp || w_timeout) w_state_next = S_DONE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Request capture, load data latch, error flag and timeout counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_req_valid) begin
            r_addr   <= i_req_addr;
            r_funct3 <= i_req_funct3;
            r_write  <= i_req_write;
            r_wdata  <= i_req_wdata;
            r_err    <= !w_legal || w_misaligned;
            r_rdata  <= '0;
          end
        end
        S_ACCESS: begin
          if (i_mem_resp) begin
            if (!r_write) r_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; memory port is quiet outside ACCESS
  always_comb begin
    o_req_ready       = (r_state == S_IDLE);
    o_mem_read        = 1'b0;
    o_mem_write       = 1'b0;
    o_mem_address     = '0;
    o_mem_wdata       = '0;
    o_mem_byte_enable = '0;
    o_resp_valid      = 1'b0;
    o_resp_err        = 1'b0;
    o_resp_rdata      = '0;
    if (r_state == S_ACCESS) begin
      o_mem_read        = !r_write;
      o_mem_write       = r_write;
      o_mem_address     = {r_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
      o_mem_byte_enable = w_size_be << w_lane;
      o_mem_wdata       = w_rep;
    end
    if (r_state == S_DONE) begin
      o_resp_valid = 1'b1;
      o_resp_err   = r_err;
      o_resp_rdata = r_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance,
// checked against a behavioural model of the load/store rules.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        req_write;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;
  logic        valid_a, valid_b, resp_a, resp_b;

  logic        a_ready, a_rv, a_re, a_mr, a_mw;
  logic [31:0] a_rdata, a_maddr, a_mwdata;
  logic [3:0]  a_be;
  logic        b_ready, b_rv, b_re, b_mr, b_mw;
  logic [63:0] b_rdata, b_mwdata;
  logic [31:0] b_maddr;
  logic [7:0]  b_be;

  mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_req_valid(valid_a), .o_req_ready(a_ready),
    .i_req_write(req_write), .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata[31:0]),
    .o_resp_valid(a_rv), .o_resp_err(a_re), .o_resp_rdata(a_rdata),
    .o_mem_read(a_mr), .o_mem_write(a_mw), .o_mem_address(a_maddr), .o_mem_wdata(a_mwdata),
    .o_mem_byte_enable(a_be), .i_mem_rdata(rdata[31:0]), .i_mem_resp(resp_a));

  mem_access_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(64)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_req_valid(valid_b), .o_req_ready(b_ready),
    .i_req_write(req_write), .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata),
    .o_resp_valid(b_rv), .o_resp_err(b_re), .o_resp_rdata(b_rdata),
    .o_mem_read(b_mr), .o_mem_write(b_mw), .o_mem_address(b_maddr), .o_mem_wdata(b_mwdata),
    .o_mem_byte_enable(b_be), .i_mem_rdata(rdata), .i_mem_resp(resp_b));

  // View of whichever instance is under test
  logic        sel64;
  logic        m_ready, m_rv, m_re, m_mr, m_mw;
  logic [63:0] m_rdata, m_maddr, m_mwdata, m_be;
  assign m_ready  = sel64 ? b_ready : a_ready;
  assign m_rv     = sel64 ? b_rv : a_rv;
  assign m_re     = sel64 ? b_re : a_re;
  assign m_mr     = sel64 ? b_mr : a_mr;
  assign m_mw     = sel64 ? b_mw : a_mw;
  assign m_rdata  = sel64 ? b_rdata : {32'b0, a_rdata};
  assign m_maddr  = sel64 ? {32'b0, b_maddr} : {32'b0, a_maddr};
  assign m_mwdata = sel64 ? b_mwdata : {32'b0, a_mwdata};
  assign m_be     = sel64 ? {56'b0, b_be} : {60'b0, a_be};

  int n_tests = 0;
  int n_fail  = 0;

  // Expectations for the transaction in flight
  bit          e_perr, e_err, e_write;
  logic [63:0] e_maddr, e_be, e_wdata, e_ld, e_rdata;
  int          e_strobes, e_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of one access, straight from the load/store rules
  function automatic void model(input bit s64, input bit wr, input logic [2:0] fn,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                                output bit perr, output logic [63:0] maddr, output logic [63:0] be,
                                output logic [63:0] mwd, output logic [63:0] ld);
    int nb, sz, lane;
    bit legal;
    logic [63:0] v, m;
    nb = s64 ? 8 : 4;
    sz = 1 << fn[1:0];
    case (fn)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
      3'd3, 3'd6:                   legal = s64;
      default:                      legal = 1'b0;
    endcase
    if (wr && fn[2]) legal = 1'b0;
    lane  = int'(a % 64'(nb));
    perr  = !legal || ((a % 64'(sz)) != 0);
    maddr = a - 64'(lane);
    be    = ((64'd1 << sz) - 64'd1) << lane;
    mwd   = '0;
    for (int i = 0; i < nb; i++) mwd[i*8 +: 8] = wd[(i % sz)*8 +: 8];
    v = rd >> (8 * lane);
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if (!fn[2] && v[8*sz-1]) v = v | ~m;
    end
    if (!s64) v = v & 64'hFFFF_FFFF;
    ld = v;
  endfunction

  // Per-cycle comparison of the memory port and response against the model
  always @(negedge clk) begin
    if (rst_a_n && rst_b_n) begin
      if (m_mr || m_mw) begin
        chk("strobe_read", m_mr, !e_write);
        chk("strobe_write", m_mw, e_write);
        chk("access_only_if_valid", e_perr, 0);
        chk("mem_address", m_maddr, e_maddr);
        chk("byte_enable", m_be, e_be);
        if (e_write) chk("mem_wdata", m_mwdata, e_wdata);
      end
      if (m_rv) begin
        chk("resp_err", m_re, e_err);
        chk("resp_rdata", m_rdata, e_rdata);
      end else begin
        chk("quiet_err", m_re, 0);
        chk("quiet_rdata", m_rdata, 0);
      end
    end
  end

  // One request; delay = strobe cycles before mem_resp is returned (-1: never)
  task automatic txn(input bit s64, input bit wr, input logic [2:0] fn, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] rd, input int delay,
                     output logic [63:0] o_rdata, output logic o_err);
    int tmo, strobes, lat;
    bit done, tmd;
    @(posedge clk); #1;
    sel64 = s64;
    tmo = s64 ? 64 : 4;
    model(s64, wr, fn, {32'b0, a}, wd, rd, e_perr, e_maddr, e_be, e_wdata, e_ld);
    e_write   = wr;
    tmd       = !e_perr && (delay < 0 || delay >= tmo);
    e_err     = e_perr || tmd;
    e_rdata   = (e_err || wr) ? 64'd0 : e_ld;
    e_strobes = e_perr ? 0 : (tmd ? tmo : delay + 1);
    e_lat     = e_strobes + 1;
    req_write = wr; f3 = fn; addr = a; wdata = wd; rdata = rd;
    @(negedge clk);
    chk("req_ready", m_ready, 1);
    if (s64) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    strobes = 0; lat = 0; done = 1'b0;
    o_rdata = '0; o_err = 1'b0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge clk);
      resp_a = 1'b0; resp_b = 1'b0;
      if (m_mr || m_mw) begin
        if (strobes == delay) begin
          if (s64) resp_b = 1'b1; else resp_a = 1'b1;
        end
        strobes++;
      end
      if (m_rv) begin
        lat = c; done = 1'b1; o_rdata = m_rdata; o_err = m_re;
      end
    end
    resp_a = 1'b0; resp_b = 1'b0;
    chk("resp_seen", done, 1);
    chk("strobe_cycles", strobes, e_strobes);
    chk("latency", lat, e_lat);
    $display("[TB] xlen=%0d wr=%0b f3=%0d addr=0x%0h strobes=%0d lat=%0d err=%0b rdata=0x%0h",
             s64 ? 64 : 32, wr, fn, a, strobes, lat, o_err, o_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] r;
  logic        e;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; sel64 = 1'b0;
    req_write = 1'b0; f3 = '0; addr = '0; wdata = '0; rdata = '0;
    valid_a = 1'b0; valid_b = 1'b0; resp_a = 1'b0; resp_b = 1'b0;
    e_write = 1'b0; e_perr = 1'b0; e_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);
    chk("rst_ready32", a_ready, 1);
    chk("rst_ready64", b_ready, 1);
    chk("rst_strobes32", {a_mr, a_mw, a_rv, a_re}, 0);
    chk("rst_strobes64", {b_mr, b_mw, b_rv, b_re}, 0);
    chk("rst_addr32", a_maddr, 0);
    chk("rst_be32", a_be, 0);

    // LW, zero-wait
    txn(0, 0, 3'b010, 32'h100, 64'd0, 64'hDEADBEEF, 0, r, e);
    chk("lw_rdata", r, 64'hDEADBEEF); chk("lw_err", e, 0);
    // LB / LBU on the top lane
    txn(0, 0, 3'b000, 32'h103, 64'd0, 64'h80FFFFFF, 0, r, e);
    chk("lb_rdata", r, 64'hFFFFFF80); chk("lb_be_model", e_be, 64'h8); chk("lb_addr_model", e_maddr, 64'h100);
    txn(0, 0, 3'b100, 32'h103, 64'd0, 64'h80FFFFFF, 1, r, e);
    chk("lbu_rdata", r, 64'h80);
    // LH / LHU
    txn(0, 0, 3'b001, 32'h102, 64'd0, 64'h7FFF0000, 0, r, e);
    chk("lh_rdata", r, 64'h7FFF);
    txn(0, 0, 3'b101, 32'h100, 64'd0, 64'h0000F00D, 0, r, e);
    chk("lhu_rdata", r, 64'hF00D);
    // SH upper half, response after two wait cycles
    txn(0, 1, 3'b001, 32'h102, 64'h1234ABCD, 64'd0, 2, r, e);
    chk("sh_be_model", e_be, 64'hC); chk("sh_wdata_model", e_wdata[31:16], 64'hABCD);
    chk("sh_rdata", r, 0); chk("sh_err", e, 0);
    txn(0, 1, 3'b000, 32'h101, 64'h000000A5, 64'd0, 0, r, e);
    chk("sb_wdata_model", e_wdata, 64'hA5A5A5A5);
    // Errors without memory access
    txn(0, 0, 3'b010, 32'h101, 64'd0, 64'hFFFFFFFF, 0, r, e);
    chk("lw_mis_err", e, 1); chk("lw_mis_rdata", r, 0);
    txn(0, 0, 3'b111, 32'h100, 64'd0, 64'hFFFFFFFF, 0, r, e);
    chk("f3_111_err", e, 1);
    txn(0, 1, 3'b100, 32'h100, 64'h11, 64'd0, 0, r, e);
    chk("store_unsigned_err", e, 1);
    txn(0, 0, 3'b011, 32'h100, 64'd0, 64'd0, 0, r, e);
    chk("ld_on_32_err", e, 1);
    txn(0, 0, 3'b101, 32'h101, 64'd0, 64'd0, 0, r, e);
    chk("lhu_mis_err", e, 1);
    // Timeout, then response on the last allowed cycle
    txn(0, 0, 3'b010, 32'h200, 64'd0, 64'h12345678, -1, r, e);
    chk("timeout_err", e, 1); chk("timeout_rdata", r, 0);
    txn(0, 0, 3'b010, 32'h200, 64'd0, 64'h12345678, 3, r, e);
    chk("late_resp_err", e, 0); chk("late_resp_rdata", r, 64'h12345678);

    // mem_resp while idle is ignored
    @(negedge clk); sel64 = 1'b0; resp_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_resp_ignored", a_rv, 0);
    resp_a = 1'b0;

    // Reset in the middle of an access
    @(posedge clk); #1;
    model(0, 0, 3'b010, 64'h300, 64'd0, 64'd0, e_perr, e_maddr, e_be, e_wdata, e_ld);
    e_write = 1'b0; e_err = 1'b0; e_rdata = 64'd0;
    req_write = 1'b0; f3 = 3'b010; addr = 32'h300;
    @(negedge clk); valid_a = 1'b1;
    @(posedge clk); #1 valid_a = 1'b0;
    @(negedge clk);
    chk("rst_mid_strobe_before", a_mr, 1);
    #2 rst_a_n = 1'b0;
    #1 chk("rst_mid_strobe_async", a_mr, 0);
    @(negedge clk); rst_a_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_no_resp", a_rv, 0);
      chk("rst_mid_no_strobe", a_mr, 0);
    end
    chk("rst_mid_ready", a_ready, 1);
    $display("[TB] reset during access: no response produced");

    // 64-bit instance
    txn(1, 0, 3'b011, 32'h8, 64'd0, 64'h0123456789ABCDEF, 0, r, e);
    chk("ld_rdata", r, 64'h0123456789ABCDEF); chk("ld_be_model", e_be, 64'hFF); chk("ld_err", e, 0);
    txn(1, 0, 3'b110, 32'hC, 64'd0, 64'h80000001_00000000, 1, r, e);
    chk("lwu_rdata", r, 64'h80000001);
    txn(1, 0, 3'b010, 32'hC, 64'd0, 64'h80000001_00000000, 0, r, e);
    chk("lw64_rdata", r, 64'hFFFFFFFF80000001);
    txn(1, 1, 3'b000, 32'h5, 64'hAB, 64'd0, 0, r, e);
    chk("sb64_be_model", e_be, 64'h20);
    txn(1, 0, 3'b011, 32'h4, 64'd0, 64'd0, 0, r, e);
    chk("ld_mis_err", e, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
